// File: rtl/led_blink_controller_pkg.sv
// Shared definitions for the LED blink peripheral: register offsets,
// CTRL bit positions and the reset blink period.
package led_blink_controller_pkg;

  typedef enum logic [1:0] {
    ADDR_LED_DATA = 2'd0,
    ADDR_CTRL     = 2'd1,
    ADDR_PERIOD   = 2'd2,
    ADDR_STATUS   = 2'd3
  } reg_addr_e;

  localparam int CTRL_BLINK_EN = 0;
  localparam int CTRL_INVERT   = 1;

  localparam logic [31:0] DEFAULT_PERIOD = 32'd50_000_000;

endpackage

// File: rtl/led_blink_controller_if.sv
// Data-memory bus slice seen by the LED peripheral. The CPU side is the
// master; the peripheral is the slave.
interface led_blink_controller_if;

  logic [31:0] writeData;
  logic        writeEnable;
  logic        readEnable;
  logic [29:0] memAddress;
  logic [31:0] readData;

  modport master (
    output writeData,
    output writeEnable,
    output readEnable,
    output memAddress,
    input  readData
  );

  modport slave (
    input  writeData,
    input  writeEnable,
    input  readEnable,
    input  memAddress,
    output readData
  );

endinterface

// File: rtl/led_blink_controller_blink_timer.sv
// Free-running half-period timer: counts 0..period-1 and toggles phase on wrap.
// A period of zero freezes the timer; restart or disable clears it.
module blink_timer (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        restart,
  input  logic [31:0] period,
  output logic        phase,
  output logic [31:0] count
);

  logic at_terminal;

  assign at_terminal = (count == (period - 32'd1));

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
      phase <= 1'b0;
    end else if (restart || !en) begin
      count <= '0;
      phase <= 1'b0;
    end else if (period != 32'd0) begin
      if (at_terminal) begin
        count <= '0;
        phase <= ~phase;
      end else begin
        count <= count + 32'd1;
      end
    end
  end

endmodule

// File: rtl/led_blink_controller.sv
// Memory-mapped LED output peripheral: pattern, control and blink-period
// registers with readback, and a registered LED drive stage.
module led_blink_controller #(
  parameter int          NUM_LEDS       = 16,
  parameter logic [31:0] DEFAULT_PERIOD = led_blink_controller_pkg::DEFAULT_PERIOD
) (
  input  logic                    clk,
  input  logic                    rst,
  led_blink_controller_if.slave   bus,
  output logic [NUM_LEDS-1:0]     leds
);

  import led_blink_controller_pkg::*;

  logic [NUM_LEDS-1:0] led_data;
  logic                blink_en;
  logic                invert;
  logic [31:0]         period;
  logic                phase;
  logic [31:0]         count;
  logic [1:0]          addr;
  logic                restart;
  logic [31:0]         rd_mux;
  logic [NUM_LEDS-1:0] base;
  logic                unused_bits;

  assign addr        = bus.memAddress[1:0];
  assign unused_bits = ^{bus.memAddress[29:2], count[31]};

  // Reprogramming CTRL or the period restarts the blink from phase 0.
  assign restart = bus.writeEnable &&
                   ((addr == ADDR_CTRL) || (addr == ADDR_PERIOD));

  blink_timer u_timer (
    .clk     (clk),
    .rst     (rst),
    .en      (blink_en),
    .restart (restart),
    .period  (period),
    .phase   (phase),
    .count   (count)
  );

  always_comb begin
    rd_mux = '0;
    case (addr)
      ADDR_LED_DATA: rd_mux[NUM_LEDS-1:0] = led_data;
      ADDR_CTRL: begin
        rd_mux[CTRL_BLINK_EN] = blink_en;
        rd_mux[CTRL_INVERT]   = invert;
      end
      ADDR_PERIOD:   rd_mux = period;
      ADDR_STATUS:   rd_mux = {count[30:0], phase};
      default:       rd_mux = '0;
    endcase
  end

  assign base = (blink_en && phase) ? '0 : led_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      led_data     <= '0;
      blink_en     <= 1'b0;
      invert       <= 1'b0;
      period       <= DEFAULT_PERIOD;
      bus.readData <= '0;
      leds         <= '0;
    end else begin
      if (bus.writeEnable) begin
        case (addr)
          ADDR_LED_DATA: led_data <= bus.writeData[NUM_LEDS-1:0];
          ADDR_CTRL: begin
            blink_en <= bus.writeData[CTRL_BLINK_EN];
            invert   <= bus.writeData[CTRL_INVERT];
          end
          ADDR_PERIOD:   period <= bus.writeData;
          default:       ;
        endcase
      end
      bus.readData <= bus.readEnable ? rd_mux : '0;
      leds         <= invert ? ~base : base;
    end
  end

endmodule

// File: tb/tb_led_blink_controller.sv
// Scoreboard bench for led_blink_controller: a cycle-level reference model
// queues expected readData/leds, a monitor pops and compares each cycle.
module tb_led_blink_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] leds;

  led_blink_controller_if bus();

  led_blink_controller #(.NUM_LEDS(16)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .leds (leds)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] rd_q[$];
  logic [15:0] led_q[$];

  // Reference state: blink derived from cycles elapsed since the last restart.
  logic [15:0]       m_led;
  logic              m_en;
  logic              m_inv;
  logic [31:0]       m_period;
  longint unsigned   m_t;

  function automatic logic [31:0] m_count();
    if (m_period == 0) return 32'd0;
    return 32'(m_t % m_period);
  endfunction

  function automatic logic m_phase();
    if (m_period == 0) return 1'b0;
    return 1'(((m_t / m_period) % 2));
  endfunction

  always @(posedge clk) begin
    logic [31:0] rdv;
    logic [31:0] cnt;
    logic [15:0] base;
    logic [1:0]  a;
    logic        ph;
    a = bus.memAddress[1:0];
    if (rst) begin
      m_led = '0; m_en = 1'b0; m_inv = 1'b0;
      m_period = 32'd50_000_000; m_t = 0;
      rd_q.push_back(32'd0);
      led_q.push_back(16'd0);
    end else begin
      ph  = m_phase();
      cnt = m_count();
      case (a)
        2'd0:    rdv = {16'd0, m_led};
        2'd1:    rdv = {30'd0, m_inv, m_en};
        2'd2:    rdv = m_period;
        default: rdv = {cnt[30:0], ph};
      endcase
      rd_q.push_back(bus.readEnable ? rdv : 32'd0);
      base = (m_en && ph) ? 16'd0 : m_led;
      led_q.push_back(m_inv ? ~base : base);
      if (bus.writeEnable && (a == 2'd1 || a == 2'd2)) m_t = 0;
      else if (!m_en) m_t = 0;
      else if (m_period != 0) m_t = m_t + 1;
      if (bus.writeEnable) begin
        case (a)
          2'd0: m_led = bus.writeData[15:0];
          2'd1: begin m_en = bus.writeData[0]; m_inv = bus.writeData[1]; end
          2'd2: m_period = bus.writeData;
          default: ;
        endcase
      end
    end
  end

  always @(negedge clk) begin
    logic [31:0] er;
    logic [15:0] el;
    if (rd_q.size() > 0) begin
      er = rd_q.pop_front();
      n_cmp++;
      if (bus.readData !== er) begin
        n_err++;
        $display("FAIL readData actual=%h required=%h at %0t", bus.readData, er, $time);
      end
    end
    if (led_q.size() > 0) begin
      el = led_q.pop_front();
      n_cmp++;
      if (leds !== el) begin
        n_err++;
        $display("FAIL leds actual=%h required=%h at %0t", leds, el, $time);
      end
    end
  end

  task automatic cyc(input logic r, input logic we, input logic re,
                     input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    rst             = r;
    bus.writeEnable = we;
    bus.readEnable  = re;
    bus.memAddress  = {28'($urandom), a};
    bus.writeData   = d;
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 1'b0, 2'd0, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] ra;
    logic [31:0] rd;
    rst = 1'b1;
    bus.writeEnable = 1'b0;
    bus.readEnable  = 1'b0;
    bus.memAddress  = '0;
    bus.writeData   = '0;
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 1, 2, 0);
    // pattern write and readback
    cyc(0, 1, 0, 0, 32'h0000_A5A5);
    idle(); idle();
    cyc(0, 0, 1, 0, 0);
    idle();
    // blink with period 4
    cyc(0, 1, 0, 2, 32'd4);
    cyc(0, 1, 0, 1, 32'h1);
    repeat (16) cyc(0, 0, 1, 3, 0);
    // invert during blink, then stop
    cyc(0, 1, 0, 1, 32'h3);
    repeat (10) cyc(0, 0, 1'($urandom_range(0, 1)), 3, 0);
    cyc(0, 1, 0, 1, 32'h0);
    repeat (3) idle();
    // zero period freezes; STATUS is read-only
    cyc(0, 1, 0, 2, 32'd0);
    cyc(0, 1, 0, 1, 32'h1);
    repeat (6) cyc(0, 0, 1, 3, 0);
    cyc(0, 1, 1, 3, 32'hFFFF_FFFF);
    cyc(0, 0, 1, 3, 0);
    cyc(0, 0, 1, 1, 0);
    // same-cycle read/write and upper-bit truncation
    cyc(0, 1, 0, 0, 32'h0000_1234);
    cyc(0, 1, 1, 0, 32'h0000_00FF);
    cyc(0, 0, 1, 0, 0);
    cyc(0, 1, 0, 0, 32'hFFFF_0001);
    cyc(0, 0, 1, 0, 0);
    // reset mid-blink with a concurrent write
    cyc(0, 1, 0, 2, 32'd3);
    cyc(0, 1, 0, 1, 32'h1);
    repeat (5) idle();
    cyc(1, 1, 1, 1, 32'h3);
    for (int i = 0; i < 4; i++) cyc(0, 0, 1, 2'(i), 0);
    idle();
    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      ra = 2'($urandom_range(0, 3));
      case (ra)
        2'd2:    rd = 32'($urandom_range(0, 6));
        default: rd = $urandom;
      endcase
      cyc(($urandom_range(0, 99) < 2), ($urandom_range(0, 3) == 0),
          1'($urandom_range(0, 1)), ra, rd);
    end
    repeat (3) idle();
    repeat (2) @(negedge clk);
    #1;
    n_cmp++;
    if (rd_q.size() != 0 || led_q.size() != 0) begin
      n_err++;
      $display("FAIL drain actual=%0d/%0d pending required=0/0", rd_q.size(), led_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
